imm_ext_pipe: RTL and testbench

// - Parametrised, pipelined immediate-extension stage for the decode path.
// - Extends an IN_W immediate to OUT_W in one of four modes (sign, zero, upper, branch-offset) and registers the result.
// - Sits between instruction decode and the ID/EX boundary, behind a valid/ready handshake.
// - A 2-entry skid buffer gives full throughput with a registered in_ready; flush squashes wrong-path immediates.

---
 rtl/imm_ext_pipe.sv | 91 +++++++++
 tb/tb_imm_ext_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// Immediate-extension stage for the decode path: sign/zero/upper/branch extension
// registered behind a 2-entry skid buffer with valid/ready on both sides.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm
);

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] upper_ext;
  logic [OUT_W-1:0] branch_ext;
  logic [OUT_W-1:0] ext_val;

  logic             main_v_reg;
  logic [OUT_W-1:0] main_d_reg;
  logic             skid_v_reg;
  logic [OUT_W-1:0] skid_d_reg;

  logic accept;
  logic consume;

  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_ext
      if (gi < IN_W) begin : g_low
        assign sign_ext[gi] = in_imm[gi];
        assign zero_ext[gi] = in_imm[gi];
      end else begin : g_high
        assign sign_ext[gi] = in_imm[IN_W-1];
        assign zero_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign upper_ext  = {in_imm, {(OUT_W-IN_W){1'b0}}};
  assign branch_ext = sign_ext << SHAMT;

  always_comb begin
    ext_val = sign_ext;
    case (in_mode)
      2'b00:   ext_val = sign_ext;
      2'b01:   ext_val = zero_ext;
      2'b10:   ext_val = upper_ext;
      default: ext_val = branch_ext;
    endcase
  end

  // Ready depends only on held state, so out_ready never reaches in_ready.
  assign in_ready  = rst_n & ~skid_v_reg;
  assign accept    = in_valid & in_ready;
  assign consume   = main_v_reg & out_ready;
  assign out_valid = main_v_reg;
  assign out_imm   = main_d_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v_reg <= 1'b0;
      main_d_reg <= '0;
      skid_v_reg <= 1'b0;
      skid_d_reg <= '0;
    end else if (flush) begin
      main_v_reg <= 1'b0;
      skid_v_reg <= 1'b0;
    end else if (!main_v_reg || consume) begin
      if (skid_v_reg) begin
        main_v_reg <= 1'b1;
        main_d_reg <= skid_d_reg;
        skid_v_reg <= 1'b0;
      end else begin
        main_v_reg <= accept;
        if (accept) main_d_reg <= ext_val;
      end
    end else if (accept) begin
      skid_v_reg <= 1'b1;
      skid_d_reg <= ext_val;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: directed scenarios plus random traffic, with a
// queue scoreboard fed on accept and drained by an independent output monitor.
module tb_imm_ext_pipe;
  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int SHAMT = 2;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [OUT_W-1:0] out_imm;

  int n_tests = 0;
  int n_fail  = 0;
  logic [OUT_W-1:0] exp_q[$];

  imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHAMT(SHAMT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm)
  );

  always #5 clk = ~clk;

  // Arithmetic view of the extension rules: values as integers, shifts as scaling.
  function automatic logic [OUT_W-1:0] ref_ext(input logic [IN_W-1:0] imm, input logic [1:0] m);
    logic signed [63:0] s;
    logic [63:0] r;
    s = 64'($signed(imm));
    case (m)
      2'd0:    r = s;
      2'd1:    r = 64'(imm);
      2'd2:    r = 64'(imm) * (64'd1 << (OUT_W - IN_W));
      default: r = s * (64'sd1 <<< SHAMT);
    endcase
    return r[OUT_W-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end else
      $display("[TB] ok   %s: %h", name, act);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IN_W-1:0] imm, input logic [1:0] m);
    logic acc;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = m;
    for (int i = 0; i < 50; i++) begin
      acc = in_ready;
      cyc();
      if (acc) return;
    end
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  // Scoreboard producer: handshake sampled mid-cycle, applied just after the edge.
  logic             acc_s, clr_s;
  logic [OUT_W-1:0] exp_s;
  always @(negedge clk) begin
    clr_s = !rst_n || flush;
    acc_s = rst_n && !flush && in_valid && in_ready;
    exp_s = ref_ext(in_imm, in_mode);
  end
  always @(posedge clk) begin
    #1;
    if (clr_s) exp_q.delete();
    else if (acc_s) exp_q.push_back(exp_s);
  end

  // Output monitor: every consumed result must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_output", 64'(out_imm), 64'hDEAD_0000_0000_0000);
      else chk("scoreboard", 64'(out_imm), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  logic [IN_W-1:0] a, b, c;
  logic [OUT_W-1:0] mode_exp [4] = '{32'hFFFF8004, 32'h00008004, 32'h80040000, 32'hFFFE0010};

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_imm = '0; in_mode = '0;
    cyc(); cyc();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_imm", 64'(out_imm), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1 chk("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Each mode on 16'h8004, one-cycle latency into an empty pipe.
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      send(16'h8004, 2'(m));
      in_valid = 1'b0;
      chk($sformatf("mode%0d_valid", m), 64'(out_valid), 64'd1);
      chk($sformatf("mode%0d_imm", m), 64'(out_imm), 64'(mode_exp[m]));
      cyc();
    end

    // Backpressure: A in main, B in skid, C stalled, then drained in order.
    a = 16'h1111; b = 16'h8222; c = 16'h7333;
    out_ready = 1'b0;
    send(a, 2'd0);
    send(b, 2'd3);
    in_valid = 1'b0;
    chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    chk("bp_main_holds_a", 64'(out_imm), 64'(ref_ext(a, 2'd0)));
    in_valid = 1'b1; in_imm = c; in_mode = 2'd2;
    cyc();
    chk("bp_c_stalled", 64'(in_ready), 64'd0);
    chk("bp_out_stable", 64'(out_imm), 64'(ref_ext(a, 2'd0)));
    out_ready = 1'b1;
    send(c, 2'd2);
    in_valid = 1'b0;
    cyc(); cyc();
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Streaming: eight back-to-back transfers at full rate.
    for (int i = 0; i < 8; i++) begin
      send(IN_W'($urandom), 2'($urandom_range(0, 3)));
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      chk("stream_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    cyc();

    // Flush with both entries held and a presented input.
    out_ready = 1'b0;
    send(16'hAAAA, 2'd1);
    send(16'hBBBB, 2'd1);
    in_valid = 1'b1; in_imm = 16'hCCCC; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    cyc(); cyc();
    chk("flush_no_leak", 64'(out_valid), 64'd0);

    // Flush with a same-cycle consume (completes) and accept (discarded).
    out_ready = 1'b0;
    send(16'h0F0F, 2'd0);
    in_valid = 1'b1; in_imm = 16'hDDDD; out_ready = 1'b1; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_out_valid", 64'(out_valid), 64'd0);
    chk("flush2_in_ready", 64'(in_ready), 64'd1);

    // Reset with the skid full.
    out_ready = 1'b0;
    send(16'h1234, 2'd0);
    send(16'h5678, 2'd0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_out_imm", 64'(out_imm), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1 chk("rst_mid_in_ready_after", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    cyc(); cyc();
    chk("rst_no_leak", 64'(out_valid), 64'd0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_imm    = IN_W'($urandom);
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_out_valid", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
